// File: rtl/datamem_pkg.sv
// Shared types and sizing helpers for the parametrised data memory.
package datamem_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int calc_nbytes(input int data_w);
    return data_w / 8;
  endfunction

  // Only one or two registered read stages are supported.
  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_RD_LAT = 1;
  localparam int DEPTH      = calc_depth(DEF_ADDR_W);
  localparam int NBYTES     = calc_nbytes(DEF_DATA_W);
  localparam bit RD_LAT_OK  = rd_lat_legal(DEF_RD_LAT);

endpackage

// File: rtl/datamem_if.sv
// Load/store bus between the CPU and datamem_param, keeping the *_DM naming.
// DATAMEM_BYTE_WRITE_EN adds the per-byte write enable be_DM.
interface datamem_if #(
  parameter int DATA_W = 16
);
  localparam int NBYTES = DATA_W / 8;

  logic              req_DM;
  logic              we_DM;
  logic [15:0]       addDM;
  logic [DATA_W-1:0] dataDM;
`ifdef DATAMEM_BYTE_WRITE_EN
  logic [NBYTES-1:0] be_DM;
`endif
  logic              ready_DM;
  logic              valid_DM;
  logic [DATA_W-1:0] outDM;
  logic              err_DM;

`ifdef DATAMEM_BYTE_WRITE_EN
  modport master (output req_DM, we_DM, addDM, dataDM, be_DM,
                  input  ready_DM, valid_DM, outDM, err_DM);
  modport slave  (input  req_DM, we_DM, addDM, dataDM, be_DM,
                  output ready_DM, valid_DM, outDM, err_DM);
`else
  modport master (output req_DM, we_DM, addDM, dataDM,
                  input  ready_DM, valid_DM, outDM, err_DM);
  modport slave  (input  req_DM, we_DM, addDM, dataDM,
                  output ready_DM, valid_DM, outDM, err_DM);
`endif

endinterface

// File: rtl/datamem_rdpipe.sv
// Read-result pipeline: LAT stages of {valid, err, data}; the last data stage
// only loads on a valid result so it doubles as the held outDM value.
module datamem_rdpipe #(
  parameter int DATA_W = 16,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid_o,
  output logic              err_o,
  output logic [DATA_W-1:0] data_o
);

  logic [LAT-1:0]    valid_q, valid_d;
  logic [LAT-1:0]    err_q, err_d;
  logic [DATA_W-1:0] data_q [LAT];
  logic [DATA_W-1:0] data_d [LAT];

  always_comb begin
    valid_d[0] = in_valid;
    err_d[0]   = in_err;
    data_d[0]  = in_data;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      data_d[i]  = data_q[i-1];
    end
    if (!valid_d[LAT-1]) data_d[LAT-1] = data_q[LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < LAT; i++) data_q[i] <= data_d[i];
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign err_o   = err_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/datamem_param.sv
// Single-port data memory with post-reset clear, range check and pipelined reads.
// Optional per-byte writes are enabled by defining DATAMEM_BYTE_WRITE_EN.
module datamem_param
  import datamem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  datamem_if.slave  bus
);

  localparam int MEM_DEPTH  = calc_depth(ADDR_W);
  localparam int MEM_NBYTES = calc_nbytes(DATA_W);
  // An unsupported latency falls back to a single read stage.
  localparam int PIPE_LAT   = rd_lat_legal(RD_LAT) ? RD_LAT : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic              addr_oor;
  logic [ADDR_W-1:0] addr_idx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data, wr_mask;
  logic              rd_valid, rd_err;
  logic [DATA_W-1:0] rd_data;
  logic              pipe_err;

  assign addr_idx = bus.addDM[ADDR_W-1:0];
  assign addr_oor = (bus.addDM >> ADDR_W) != 16'd0;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wr_err_d     = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = init_cnt_q;
    wr_data      = '0;
    wr_mask      = '1;
    rd_valid     = 1'b0;
    rd_err       = 1'b0;
    rd_data      = '0;
    bus.ready_DM = 1'b0;
    case (state_q)
      ST_INIT: begin
        wr_en      = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_W'(MEM_DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        bus.ready_DM = 1'b1;
        // Reset wins over a request presented on the same edge.
        if (bus.req_DM && !rst) begin
          if (bus.we_DM) begin
            wr_err_d = addr_oor;
            wr_en    = !addr_oor;
            wr_idx   = addr_idx;
            wr_data  = bus.dataDM;
`ifdef DATAMEM_BYTE_WRITE_EN
            for (int i = 0; i < MEM_NBYTES; i++)
              wr_mask[i*8 +: 8] = {8{bus.be_DM[i]}};
`endif
          end else begin
            rd_valid = 1'b1;
            rd_err   = addr_oor;
            rd_data  = addr_oor ? '0 : mem_q[addr_idx];
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
  end

  datamem_rdpipe #(
    .DATA_W (DATA_W),
    .LAT    (PIPE_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_valid),
    .in_err   (rd_err),
    .in_data  (rd_data),
    .valid_o  (bus.valid_DM),
    .err_o    (pipe_err),
    .data_o   (bus.outDM)
  );

  assign bus.err_DM = pipe_err | wr_err_q;

endmodule

// File: tb/tb_datamem_param.sv
// Randomised self-checking bench for datamem_param against a queue-based model.
// Byte-enable checks are included when DATAMEM_BYTE_WRITE_EN is defined.
module tb_datamem_param;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  datamem_if #(.DATA_W(DATA_W)) bus ();

  datamem_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    logic              err;
  } rd_t;

  rd_t               pend[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                init_left = 0;
  int                edge_no   = 0;
  int                n_checks  = 0;
  int                n_pass    = 0;
  logic              exp_valid = 1'b0;
  logic              exp_err   = 1'b0;
  logic [DATA_W-1:0] exp_out   = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s at edge %0d: got %0h expected %0h",
                  tag, edge_no, observed, expected);
  endtask

  // Drive one cycle, advance the model by one edge, then compare all outputs.
  task automatic applyStimulus(input logic r, input logic q, input logic w,
                               input logic [15:0] a, input logic [DATA_W-1:0] d,
                               input logic [NBYTES-1:0] be);
    logic [NBYTES-1:0] be_eff;
    bit                accept;
    bit                oor;
    rd_t               ent;
    rst        = r;
    bus.req_DM = q;
    bus.we_DM  = w;
    bus.addDM  = a;
    bus.dataDM = d;
`ifdef DATAMEM_BYTE_WRITE_EN
    bus.be_DM  = be;
`endif
    be_eff = be;
`ifndef DATAMEM_BYTE_WRITE_EN
    be_eff = '1;
`endif
    @(posedge clk);
    edge_no++;
    if (r) begin
      init_left = DEPTH;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      pend.delete();
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_out   = '0;
    end else begin
      accept = q && (init_left == 0);
      if (init_left > 0) init_left--;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (accept) begin
        oor = (a >= DEPTH);
        if (w) begin
          if (oor) exp_err = 1'b1;
          else
            for (int b = 0; b < NBYTES; b++)
              if (be_eff[b]) ref_mem[a[ADDR_W-1:0]][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          ent.due  = edge_no + RD_LAT - 1;
          ent.data = oor ? '0 : ref_mem[a[ADDR_W-1:0]];
          ent.err  = oor;
          pend.push_back(ent);
        end
      end
      if (pend.size() > 0 && pend[0].due == edge_no) begin
        ent       = pend.pop_front();
        exp_valid = 1'b1;
        exp_out   = ent.data;
        exp_err   = exp_err | ent.err;
      end
    end
    #1;
    checkOutput("ready_DM", 64'(bus.ready_DM), 64'(init_left == 0));
    checkOutput("valid_DM", 64'(bus.valid_DM), 64'(exp_valid));
    checkOutput("err_DM",   64'(bus.err_DM),   64'(exp_err));
    checkOutput("outDM",    64'(bus.outDM),    64'(exp_out));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, '0, '1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [DATA_W-1:0] d,
                    input logic [NBYTES-1:0] be);
    applyStimulus(1'b0, 1'b1, 1'b1, a, d, be);
  endtask

  task automatic rd(input logic [15:0] a);
    applyStimulus(1'b0, 1'b1, 1'b0, a, DATA_W'($urandom), '1);
  endtask

  initial begin
    rst        = 1'b1;
    bus.req_DM = 1'b0;
    bus.we_DM  = 1'b0;
    bus.addDM  = '0;
    bus.dataDM = '0;
`ifdef DATAMEM_BYTE_WRITE_EN
    bus.be_DM  = '1;
`endif

    // Clear sequence, with random requests that must be ignored meanwhile.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, '0, '1);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 16'($urandom_range(0, DEPTH - 1)),
                    DATA_W'($urandom), '1);
    for (int i = 0; i < DEPTH; i++) rd(16'(i));
    idle(RD_LAT + 1);

    // Write then back-to-back reads.
    wr(16'd0, 16'h1dfe, '1);
    wr(16'd1, 16'h1001, '1);
    wr(16'd2, 16'ha001, '1);
    rd(16'd0);
    rd(16'd1);
    rd(16'd2);
    idle(RD_LAT + 1);

    // Read-after-write on the next cycle.
    wr(16'd7, 16'h5a5a, '1);
    rd(16'd7);
    idle(RD_LAT + 1);

    // Out-of-range write and read.
    wr(16'd3, 16'h3c3c, '1);
    wr(16'h0013, 16'hffff, '1);
    rd(16'd3);
    idle(RD_LAT + 1);
    rd(16'h0100);
    idle(RD_LAT + 1);

    // Reset while a read is in flight.
    rd(16'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, '0, '1);
    idle(DEPTH);
    rd(16'd2);
    idle(RD_LAT + 1);

`ifdef DATAMEM_BYTE_WRITE_EN
    wr(16'd4, 16'h1234, 2'b11);
    wr(16'd4, 16'hABCD, 2'b10);
    rd(16'd4);
    idle(RD_LAT + 1);
    wr(16'd4, 16'h5555, 2'b00);
    rd(16'd4);
    idle(RD_LAT + 1);
`endif

    // Random traffic with occasional out-of-range addresses and resets.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(DEPTH, 65535));
      else                           a = 16'($urandom_range(0, DEPTH - 1));
      applyStimulus(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom), a, DATA_W'($urandom), NBYTES'($urandom));
    end
    idle(RD_LAT + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/datamem_param.md
Name: datamem_param

Overview:
Parametrised, synchronous-reset successor to the CPU data memory. It is a single-port RAM with a request/ready handshake, a configurable registered read latency, a post-reset clear sequence and out-of-range address detection. It sits between the CPU load/store stage and the storage array and keeps the `*_DM` port naming of the existing data-memory interface.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 4, index bits; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles from accept to valid_DM; legal values 1 or 2.

Ports:
- clk  in  1  single clock; everything is updated on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req_DM  in  1  request strobe.
- we_DM  in  1  1 = write, 0 = read; sampled with req_DM.
- addDM  in  16  word address; only bits [ADDR_W-1:0] index the array.
- dataDM  in  DATA_W  write data.
- ready_DM  out  1  block can accept a request this cycle.
- valid_DM  out  1  one-cycle pulse; outDM holds new read data.
- outDM  out  DATA_W  read data; holds its value between reads.
- err_DM  out  1  one-cycle pulse; the accepted request had an out-of-range address.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ready_DM=0, valid_DM=0, outDM=0, err_DM=0. The read pipeline is flushed and the FSM enters ST_INIT.
- FSM ST_INIT:
  - Writes 0 to word init_cnt each cycle, with init_cnt counting 0..DEPTH-1.
  - ready_DM=0 throughout; requests are ignored, not queued.
  - After writing word DEPTH-1, moves to ST_RUN.
  - ready_DM first reads 1 exactly DEPTH cycles after rst deasserts.
- FSM ST_RUN:
  - ready_DM=1 every cycle.
  - A request is accepted on any edge where req_DM=1 and ready_DM=1. Back-to-back requests are accepted every cycle.
- Write accept:
  - mem[addDM[ADDR_W-1:0]] <= dataDM at the accepting edge.
  - No valid_DM pulse.
- Read accept:
  - The array is read at the accepting edge.
  - outDM updates and valid_DM=1 RD_LAT cycles later.
  - Reads are pipelined: one result per cycle.
- Read-after-write:
  - A read accepted in the cycle after a write to the same address returns the new data.
  - No same-cycle conflict can occur on a single port.
- Range check: an address is out of range when addDM[15:ADDR_W] != 0.
  - Write: dropped; the array is unchanged.
  - Read: returns 0 with the normal valid_DM timing.
  - err_DM pulses, aligned with valid_DM for reads and one cycle after accept for writes.
- Address indexing: there is no wrap-around; only the low ADDR_W bits index, and any nonzero upper bit is an error.
- Reset mid-operation:
  - In-flight reads are discarded, so no valid_DM is produced for them.
  - The clear sequence restarts from word 0.
  - Memory contents after reset are always all zero.
- Unused signals: dataDM is ignored on reads; we_DM and addDM are ignored when req_DM=0.

Optional Feature:
- Macro: DATAMEM_BYTE_WRITE_EN.
- Defined:
  - Adds input be_DM of width DATA_W/8.
  - On a write accept, only the bytes with be_DM[i]=1 are updated.
  - be_DM=0 is a legal no-op write; err_DM still applies.
  - Reads are unaffected.
- Undefined:
  - No be_DM port.
  - Every write updates the full word.

Decomposition:
- Package datamem_pkg:
  - State enum {ST_INIT, ST_RUN}.
  - Localparam helpers DEPTH and NBYTES = DATA_W/8.
  - Legal-RD_LAT check constant.
- Sub-module datamem_rdpipe:
  - RD_LAT-deep shift register of {valid, err, data}.
  - Same-cycle synchronous clear on rst.
  - Drives valid_DM, err_DM (read case) and holds outDM.

Test Plan:
1. Clear sequence: pulse rst for 1 cycle (ADDR_W=4) -> ready_DM=0 for 16 cycles, then 1; read every address 0..15 -> outDM=0 each time, valid_DM on each.
2. Write then read: write 16'h1dfe@0, 16'h1001@1, 16'ha001@2, then read 0,1,2 back-to-back -> valid_DM on 3 consecutive cycles with 1dfe, 1001, a001. Run with RD_LAT=1 and RD_LAT=2 and check the valid timing for each.
3. Read-after-write: write 16'h5a5a@7, read @7 next cycle -> outDM=16'h5a5a after RD_LAT cycles.
4. Out of range:
   - write 16'hffff@16'h0013 -> err_DM pulse; read @3 afterwards returns its old value, not ffff.
   - read @16'h0100 -> outDM=0, err_DM and valid_DM pulse together.
5. Reset mid-operation: issue read @2 (holding 16'ha001), assert rst on the next edge -> no valid_DM for that read, outDM=0, ready_DM low for 16 cycles; read @2 afterwards -> 0.
6. Byte writes (DATAMEM_BYTE_WRITE_EN): word @4 = 16'h1234; write 16'hABCD with be_DM=2'b10 -> read gives 16'hAB34; write with be_DM=2'b00 -> unchanged.
